// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the two-client AXI4 RAM arbiter.
//   arb_state_e    : transaction sequencer states
//   NUM_CLIENTS    : number of requesting clients
//   TIMEOUT_RDATA  : read data returned when the watchdog aborts a transaction
//   client_onehot  : client index -> one-hot client vector
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  localparam int          NUM_CLIENTS   = 2;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,  // waiting for a request
    ST_WR,    // AW and W in flight
    ST_WB,    // waiting for B
    ST_RA,    // AR in flight
    ST_RD     // waiting for R
  } arb_state_e;

  function automatic logic [NUM_CLIENTS-1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi4_ram_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin arbiter.
//   req_i        : request vector, bit i = client i
//   last_grant_i : client that won the previous arbitration
//   grant_o      : one-hot grant (all zero when nothing is requested)
// A lone requester always wins; on a tie the client that did not win last
// time is granted.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    // NOTE: default first so every path assigns grant_o; no latch is inferred.
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi4_ram_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_ram_arbiter
// Two-client front end for a single-beat AXI4 RAM slave. Accepts one request
// at a time (round-robin between clients), runs AW/W/B or AR/R for it, and
// returns a one-cycle response pulse to the owning client.
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/we/addr/wdata/wstrb   : client requests, {client1, client0}
//   req_ready                       : one-hot accept pulse
//   rsp_valid, rsp_rdata, rsp_err   : one-hot completion pulse, read data,
//                                     watchdog flag
//   aw*/w*/b*/ar*/r*                : AXI4 master channels to the RAM slave
//
// Configuration
//   ARB_TIMEOUT_EN : when defined, a watchdog aborts any transaction that has
//                    not completed TIMEOUT_CYCLES cycles after accept and
//                    returns rsp_err=1 with rsp_rdata=TIMEOUT_RDATA.
//
// Every output comes straight from a register, so there is no combinational
// path from req_* or slave inputs to any output.
// -----------------------------------------------------------------------------
module axi4_ram_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        awvalid,
  output logic [31:0] awaddr,
  input  logic        awready,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  output logic        rready
);

  arb_state_e  state_q;
  logic        last_grant_q;
  logic        owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        aw_done_q, w_done_q;
  logic [1:0]  req_ready_q, rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [1:0]  grant;
  logic        win;
  logic        aw_hs, w_hs, aw_done, w_done, completing;

  rr_arbiter2 u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign win     = grant[1];
  assign aw_hs   = awvalid_q & awready;
  assign w_hs    = wvalid_q & wready;
  assign aw_done = aw_done_q | aw_hs;
  assign w_done  = w_done_q | w_hs;
  assign completing = ((state_q == ST_WB) && bvalid) || ((state_q == ST_RD) && rvalid);

`ifdef ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`else
  // Watchdog compiled out; the parameter stays so both builds share one interface.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // NOTE: only control/data registers exist here (no memories), and all of
  // them are reset so a mid-transaction reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; each register sees last cycle's values.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ready_q  <= grant;
            owner_q      <= win;
            last_grant_q <= win;
            addr_q       <= req_addr[{win, 5'd0} +: 32];
            wdata_q      <= req_wdata[{win, 5'd0} +: 32];
            wstrb_q      <= req_wstrb[{win, 2'd0} +: 4];
            if (req_we[win]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RA;
            end
          end
        end
        ST_WR: begin
          // AW and W complete independently, in either order.
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done;
          w_done_q  <= w_done;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WB;
          end
        end
        ST_WB: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= client_onehot(owner_q);
            state_q     <= ST_IDLE;
          end
        end
        ST_RA: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD;
          end
        end
        ST_RD: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= rdata;
            rsp_valid_q <= client_onehot(owner_q);
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

`ifdef ARB_TIMEOUT_EN
      // Counter runs from accept; a completion in the limit cycle still wins.
      if (state_q == ST_IDLE) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
        if (!completing && (tmo_cnt_q == TMO_LAST)) begin
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= client_onehot(owner_q);
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= TIMEOUT_RDATA;
          state_q     <= ST_IDLE;
        end
      end
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;

`ifdef ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  logic unused_completing;
  assign unused_completing = completing | rsp_err_q;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_ram_arbiter
// Self-checking bench for axi4_ram_arbiter. A small RAM slave (ready one cycle
// after valid, optional B/R stalls) sits on the AXI side; a reference model
// (word array + last-granted client + last read data) predicts grant order,
// response owner, read data and error flag. Build with ARB_TIMEOUT_EN to
// exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_axi4_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi4_ram_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  logic all_out_or;
  assign all_out_or = |{req_ready, rsp_valid, rsp_rdata, rsp_err, awvalid, awaddr,
                        wvalid, wdata, wstrb, bready, arvalid, araddr, rready};

  int vectors = 0;
  int miscompares = 0;

  // ---------------- RAM slave ----------------
  logic [31:0] slv_mem [16];
  int b_stall = 0, r_stall = 0, b_cnt, r_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0; rdata  <= '0;
      b_cnt   <= 0;    r_cnt  <= 0;
    end else begin
      awready <= awvalid && !awready;
      wready  <= wvalid && !wready;
      arready <= arvalid && !arready;
      if (wvalid && wready) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) slv_mem[awaddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
        if (b_stall == 0) bvalid <= 1'b1;
        else b_cnt <= b_stall;
      end else if (b_cnt > 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rdata <= slv_mem[araddr[5:2]];
        if (r_stall == 0) rvalid <= 1'b1;
        else r_cnt <= r_stall;
      end else if (r_cnt > 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) rvalid <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  logic        model_last;
  logic [31:0] model_rdata;
  bit          expect_tmo = 1'b0;
  int          lat_min = -1, lat_max = -1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    model_last  = 1'b1;
    model_rdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Present up to two requests at once and follow them to completion.
  task automatic run_round(input string tag, input logic [1:0] act, input logic [1:0] we,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0]  pending;
    logic        inflight, cur, nxt, cur_we;
    logic [31:0] cur_addr, cur_data, exp;
    logic [3:0]  cur_strb;
    int          lat;
    bit          done;
    @(negedge clk);
    req_we = we; req_addr = {a1, a0}; req_wdata = {d1, d0}; req_wstrb = {s1, s0};
    req_valid = act;
    pending = act; inflight = 1'b0; cur = 1'b0; lat = 0; done = 1'b0;
    cur_we = 1'b0; cur_addr = '0; cur_data = '0; cur_strb = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (inflight) lat++;
      if (rsp_valid != 2'b00) begin
        check({tag, "_rsp_owner"}, rsp_valid, onehot(cur));
        if (cur_we) ref_mem[cur_addr[5:2]] = merge(ref_mem[cur_addr[5:2]], cur_data, cur_strb);
        if (expect_tmo) exp = 32'hDEADBEEF;
        else if (cur_we) exp = model_rdata;
        else exp = ref_mem[cur_addr[5:2]];
        model_rdata = exp;
        check({tag, "_rdata"}, rsp_rdata, exp);
        check({tag, "_err"}, rsp_err, expect_tmo);
        if (lat_min >= 0) check({tag, "_latency_ok"}, (lat >= lat_min && lat <= lat_max), 1);
        inflight = 1'b0;
      end
      if (req_ready != 2'b00) begin
        check({tag, "_accept_while_busy"}, inflight, 0);
        nxt = (pending == 2'b11) ? ~model_last : pending[1];
        check({tag, "_grant"}, req_ready, onehot(nxt));
        cur = nxt; model_last = nxt; pending[nxt] = 1'b0; req_valid[nxt] = 1'b0;
        cur_we   = req_we[nxt];
        cur_addr = nxt ? req_addr[63:32] : req_addr[31:0];
        cur_data = nxt ? req_wdata[63:32] : req_wdata[31:0];
        cur_strb = nxt ? req_wstrb[7:4] : req_wstrb[3:0];
        inflight = 1'b1; lat = 0;
      end
      done = (pending == 2'b00) && !inflight;
    end
    check({tag, "_complete"}, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit seen_rd;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'hA5A5_0000 | i;
      ref_mem[i] = 32'hA5A5_0000 | i;
    end
    rst_n = 1'b0; req_valid = '0; req_we = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    model_reset();
    #1;
    check("reset_outputs", all_out_or, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_out_or, 0);

    // Simultaneous reads straight after reset: client0 then client1.
    lat_min = 3; lat_max = 3;
    run_round("dual_read", 2'b11, 2'b00, 32'h0, 32'h4, '0, '0, '0, '0);

    // Write then read back on client 0.
    run_round("c0_write", 2'b01, 2'b01, 32'h10, '0, 32'h1234_5678, '0, 4'hF, '0);
    run_round("c0_read", 2'b01, 2'b00, 32'h10, '0, '0, '0, '0, '0);
    check("c0_read_value", rsp_rdata, 32'h1234_5678);

    // Partial strobe write, read back by client 1.
    run_round("strb_write", 2'b01, 2'b01, 32'h8, '0, 32'hFFFF_FFFF, '0, 4'b0011, '0);
    run_round("strb_read", 2'b10, 2'b00, '0, 32'h8, '0, '0, '0, '0);
    check("strb_read_value", rsp_rdata, 32'hA5A5_FFFF);

    // Slave withholds B for 100 cycles.
    b_stall = 100;
`ifdef ARB_TIMEOUT_EN
    expect_tmo = 1'b1; lat_min = 64; lat_max = 65;
`else
    lat_min = 100; lat_max = 110;
`endif
    run_round("b_stall", 2'b01, 2'b01, 32'h14, '0, 32'hCAFE_F00D, '0, 4'hF, '0);
    expect_tmo = 1'b0; b_stall = 0; lat_min = -1; lat_max = -1;
    apply_reset();

    // Reset while waiting for R: everything drops, nothing is returned.
    r_stall = 20;
    @(negedge clk);
    req_we = '0; req_addr = {32'hC, 32'h0}; req_valid = 2'b10;
    seen_rd = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen_rd; cyc++) begin
      @(negedge clk);
      if (req_ready != 2'b00) req_valid = '0;
      if (rready) seen_rd = 1'b1;
    end
    check("rdrst_reached_rd", seen_rd, 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("rdrst_outputs", all_out_or, 0);
    @(negedge clk);
    check("rdrst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    model_reset();
    r_stall = 0;
    lat_min = 3; lat_max = 3;
    run_round("after_rst", 2'b01, 2'b00, 32'hC, '0, '0, '0, '0, '0);
    lat_min = -1; lat_max = -1;

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] act;
      act = 2'($urandom_range(1, 3));
      b_stall = $urandom_range(0, 3);
      r_stall = $urandom_range(0, 3);
      run_round("rand", act, 2'($urandom),
                {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom, $urandom, 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
